// File: rtl/iob2axil_ot.sv
// iob2axil_ot: native iob slave to AXI4-Lite master bridge.
// One request slot feeds the AW/W or AR channel; up to MAX_OT transactions
// per direction may be in flight. Writes are posted, reads return in order
// one cycle after their R handshake. AXI and protocol errors are sticky.
module iob2axil_ot #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter int          MAX_OT = 4,
    parameter logic [2:0]  PROT   = 3'b010
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    // iob slave side
    input  logic                  i_iob_valid,
    input  logic [ADDR_W-1:0]     i_iob_addr,
    input  logic [DATA_W-1:0]     i_iob_wdata,
    input  logic [DATA_W/8-1:0]   i_iob_wstrb,
    output logic                  o_iob_ready,
    output logic                  o_iob_rvalid,
    output logic [DATA_W-1:0]     o_iob_rdata,
    output logic                  o_iob_rerr,
    // status
    output logic [1:0]            o_err,
    input  logic                  i_err_clr,
    output logic                  o_idle,
    // AXI4-Lite write address
    output logic [ADDR_W-1:0]     o_axil_awaddr,
    output logic [2:0]            o_axil_awprot,
    output logic                  o_axil_awvalid,
    input  logic                  i_axil_awready,
    // AXI4-Lite write data
    output logic [DATA_W-1:0]     o_axil_wdata,
    output logic [DATA_W/8-1:0]   o_axil_wstrb,
    output logic                  o_axil_wvalid,
    input  logic                  i_axil_wready,
    // AXI4-Lite write response
    input  logic [1:0]            i_axil_bresp,
    input  logic                  i_axil_bvalid,
    output logic                  o_axil_bready,
    // AXI4-Lite read address
    output logic [ADDR_W-1:0]     o_axil_araddr,
    output logic [2:0]            o_axil_arprot,
    output logic                  o_axil_arvalid,
    input  logic                  i_axil_arready,
    // AXI4-Lite read data
    input  logic [DATA_W-1:0]     i_axil_rdata,
    input  logic [1:0]            i_axil_rresp,
    input  logic                  i_axil_rvalid,
    output logic                  o_axil_rready
);

    localparam int              OT_W     = $clog2(MAX_OT + 1);
    localparam int              STRB_W   = DATA_W / 8;
    localparam logic [OT_W-1:0] OT_ZERO  = {OT_W{1'b0}};
    localparam logic [OT_W-1:0] OT_ONE   = {{(OT_W-1){1'b0}}, 1'b1};
    localparam logic [OT_W-1:0] OT_MAX   = OT_W'(MAX_OT);

    // Next value of an outstanding counter; an accept paired with a real
    // response leaves it unchanged. Spurious responses never reach dec.
    function automatic logic [OT_W-1:0] f_ot_next(input logic [OT_W-1:0] cur,
                                                  input logic            inc,
                                                  input logic            dec);
        logic [OT_W-1:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cur + OT_ONE;
            2'b01:   nxt = cur - OT_ONE;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // slot contents and pending-channel flags
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_aw_pend;
    logic              r_w_pend;
    logic              r_ar_pend;
    // in-flight counters
    logic [OT_W-1:0]   r_wr_ot;
    logic [OT_W-1:0]   r_rd_ot;
    // status and read return
    logic [1:0]        r_err;
    logic              r_iob_rvalid;
    logic [DATA_W-1:0] r_iob_rdata;
    logic              r_iob_rerr;

    logic              w_slot_empty;
    logic              w_req_wr;
    logic              w_iob_ready;
    logic              w_accept;
    logic              w_acc_wr;
    logic              w_acc_rd;
    logic              w_b_spur;
    logic              w_r_spur;
    logic              w_b_dec;
    logic              w_r_dec;
    logic              w_resp_err;

    // The slot is busy exactly while any channel still waits for its handshake,
    // so it frees the cycle after the last flag drops.
    assign w_slot_empty = ~(r_aw_pend | r_w_pend | r_ar_pend);
    assign w_req_wr     = |i_iob_wstrb;

    // Accept only into an empty slot, with room in the requested direction and
    // the opposite direction fully drained (keeps reads ordered after writes).
    always_comb begin
        w_iob_ready = 1'b0;
        if (!w_slot_empty) begin
            w_iob_ready = 1'b0;
        end else if (w_req_wr) begin
            w_iob_ready = (r_wr_ot < OT_MAX) && (r_rd_ot == OT_ZERO);
        end else begin
            w_iob_ready = (r_rd_ot < OT_MAX) && (r_wr_ot == OT_ZERO);
        end
    end

    assign w_accept   = i_iob_valid & w_iob_ready;
    assign w_acc_wr   = w_accept & w_req_wr;
    assign w_acc_rd   = w_accept & ~w_req_wr;
    assign w_b_spur   = i_axil_bvalid & (r_wr_ot == OT_ZERO);
    assign w_r_spur   = i_axil_rvalid & (r_rd_ot == OT_ZERO);
    assign w_b_dec    = i_axil_bvalid & ~w_b_spur;
    assign w_r_dec    = i_axil_rvalid & ~w_r_spur;
    assign w_resp_err = (i_axil_bvalid & i_axil_bresp[1]) | (i_axil_rvalid & i_axil_rresp[1]);

    // Request slot: load on accept, then retire each channel on its own handshake.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr    <= {ADDR_W{1'b0}};
            r_wdata   <= {DATA_W{1'b0}};
            r_wstrb   <= {STRB_W{1'b0}};
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_ar_pend <= 1'b0;
        end else if (w_accept) begin
            r_addr    <= i_iob_addr;
            r_wdata   <= i_iob_wdata;
            r_wstrb   <= i_iob_wstrb;
            r_aw_pend <= w_req_wr;
            r_w_pend  <= w_req_wr;
            r_ar_pend <= ~w_req_wr;
        end else begin
            if (r_aw_pend && i_axil_awready) r_aw_pend <= 1'b0;
            if (r_w_pend && i_axil_wready)   r_w_pend  <= 1'b0;
            if (r_ar_pend && i_axil_arready) r_ar_pend <= 1'b0;
        end
    end

    // Outstanding counters: count at accept, release on a genuine response.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ot <= OT_ZERO;
            r_rd_ot <= OT_ZERO;
        end else begin
            r_wr_ot <= f_ot_next(r_wr_ot, w_acc_wr, w_b_dec);
            r_rd_ot <= f_ot_next(r_rd_ot, w_acc_rd, w_r_dec);
        end
    end

    // Sticky errors: clear request drops old bits, a fresh error in the same cycle survives.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err <= 2'b00;
        end else begin
            r_err <= (r_err & ~{2{i_err_clr}}) | {(w_b_spur | w_r_spur), w_resp_err};
        end
    end

    // Read return: every R beat (spurious or not) is forwarded one cycle later.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_iob_rvalid <= 1'b0;
            r_iob_rdata  <= {DATA_W{1'b0}};
            r_iob_rerr   <= 1'b0;
        end else begin
            r_iob_rvalid <= i_axil_rvalid;
            if (i_axil_rvalid) begin
                r_iob_rdata <= i_axil_rdata;
                r_iob_rerr  <= i_axil_rresp[1];
            end
        end
    end

    assign o_iob_ready    = w_iob_ready;
    assign o_iob_rvalid   = r_iob_rvalid;
    assign o_iob_rdata    = r_iob_rdata;
    assign o_iob_rerr     = r_iob_rerr;
    assign o_err          = r_err;
    assign o_idle         = w_slot_empty & (r_wr_ot == OT_ZERO) & (r_rd_ot == OT_ZERO);

    assign o_axil_awaddr  = r_addr;
    assign o_axil_awprot  = PROT;
    assign o_axil_awvalid = r_aw_pend;
    assign o_axil_wdata   = r_wdata;
    assign o_axil_wstrb   = r_wstrb;
    assign o_axil_wvalid  = r_w_pend;
    assign o_axil_bready  = 1'b1;
    assign o_axil_araddr  = r_addr;
    assign o_axil_arprot  = PROT;
    assign o_axil_arvalid = r_ar_pend;
    assign o_axil_rready  = 1'b1;

endmodule

// File: tb/tb_iob2axil_ot.sv
// Testbench for iob2axil_ot: directed scenarios followed by a randomized
// mixed-traffic run against a memory reference model and a behavioural AXI slave.
module tb_iob2axil_ot;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iob_valid = 1'b0;
    logic [31:0] iob_addr = 32'h0;
    logic [31:0] iob_wdata = 32'h0;
    logic [3:0]  iob_wstrb = 4'h0;
    logic        iob_ready, iob_rvalid, iob_rerr, idle;
    logic [31:0] iob_rdata;
    logic [1:0]  err;
    logic        err_clr = 1'b0;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;

    int errors = 0;
    int checks = 0;

    iob2axil_ot dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_iob_valid(iob_valid), .i_iob_addr(iob_addr), .i_iob_wdata(iob_wdata),
        .i_iob_wstrb(iob_wstrb), .o_iob_ready(iob_ready), .o_iob_rvalid(iob_rvalid),
        .o_iob_rdata(iob_rdata), .o_iob_rerr(iob_rerr),
        .o_err(err), .i_err_clr(err_clr), .o_idle(idle),
        .o_axil_awaddr(awaddr), .o_axil_awprot(awprot), .o_axil_awvalid(awvalid),
        .i_axil_awready(awready),
        .o_axil_wdata(wdata), .o_axil_wstrb(wstrb), .o_axil_wvalid(wvalid),
        .i_axil_wready(wready),
        .i_axil_bresp(bresp), .i_axil_bvalid(bvalid), .o_axil_bready(bready),
        .o_axil_araddr(araddr), .o_axil_arprot(arprot), .o_axil_arvalid(arvalid),
        .i_axil_arready(arready),
        .i_axil_rdata(rdata), .i_axil_rresp(rresp), .i_axil_rvalid(rvalid),
        .o_axil_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (s[b]) res[8*b +: 8] = d[8*b +: 8];
        return res;
    endfunction

    // reference model and behavioural slave state for the random run
    logic [31:0] ref_mem [8];
    logic [31:0] s_mem [8];
    logic [31:0] exp_rd_q [$];
    logic [31:0] s_aw_q [$];
    logic [31:0] s_wd_q [$];
    logic [3:0]  s_ws_q [$];
    logic [31:0] s_r_q [$];
    int          s_b_cnt = 0;
    logic        req_pending = 1'b0;
    logic        r_hs_prev = 1'b0;
    int          ops_done = 0, wr_acc = 0, rd_acc = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, rd_ret = 0;
    logic        pv_aw = 1'b0, pr_aw = 1'b0, pv_w = 1'b0, pr_w = 1'b0, pv_ar = 1'b0, pr_ar = 1'b0;
    logic [31:0] pa_addr = 32'h0, pw_data = 32'h0, par_addr = 32'h0;
    logic [3:0]  pw_strb = 4'h0;

    // One random cycle: check last edge's results, drive new inputs, record handshakes.
    task automatic rnd_cycle(input bit issue);
        logic [31:0] e;
        chk("rnd_rvalid", iob_rvalid, r_hs_prev);
        if (r_hs_prev) begin
            chk("rnd_rd_pending", exp_rd_q.size() != 0, 1);
            if (exp_rd_q.size() != 0) begin
                e = exp_rd_q.pop_front();
                rd_ret++;
                chk("rnd_rdata", iob_rdata, e);
                chk("rnd_rerr", iob_rerr, 0);
            end
        end
        if (pv_aw && !pr_aw) chk("rnd_aw_hold", {awvalid, awaddr}, {1'b1, pa_addr});
        if (pv_w && !pr_w)   chk("rnd_w_hold", {wvalid, wstrb, wdata}, {1'b1, pw_strb, pw_data});
        if (pv_ar && !pr_ar) chk("rnd_ar_hold", {arvalid, araddr}, {1'b1, par_addr});

        if (issue && !req_pending && $urandom_range(0, 9) < 7) begin
            req_pending = 1'b1;
            iob_addr    = 32'h1000 + ($urandom_range(0, 7) << 2);
            iob_wdata   = $urandom;
            iob_wstrb   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
        iob_valid = req_pending;
        awready = 1'($urandom_range(0, 1));
        wready  = 1'($urandom_range(0, 1));
        arready = 1'($urandom_range(0, 1));
        bvalid = 1'b0;
        if (s_b_cnt > 0 && $urandom_range(0, 2) != 0) begin
            bvalid = 1'b1;
            s_b_cnt--;
        end
        rvalid = 1'b0;
        if (s_r_q.size() != 0 && $urandom_range(0, 2) != 0) begin
            rvalid = 1'b1;
            rdata  = s_r_q.pop_front();
        end
        r_hs_prev = rvalid;
        #2;
        if (iob_valid && iob_ready) begin
            if (iob_wstrb != 4'h0) begin
                ref_mem[iob_addr[4:2]] = merge(ref_mem[iob_addr[4:2]], iob_wdata, iob_wstrb);
                wr_acc++;
            end else begin
                exp_rd_q.push_back(ref_mem[iob_addr[4:2]]);
                rd_acc++;
            end
            req_pending = 1'b0;
            ops_done++;
        end
        if (awvalid && awready) begin s_aw_q.push_back(awaddr); aw_hs++; end
        if (wvalid && wready) begin s_wd_q.push_back(wdata); s_ws_q.push_back(wstrb); w_hs++; end
        if (arvalid && arready) begin s_r_q.push_back(s_mem[araddr[4:2]]); ar_hs++; end
        while (s_aw_q.size() != 0 && s_wd_q.size() != 0) begin
            logic [31:0] a;
            a = s_aw_q.pop_front();
            s_mem[a[4:2]] = merge(s_mem[a[4:2]], s_wd_q.pop_front(), s_ws_q.pop_front());
            s_b_cnt++;
        end
        pv_aw = awvalid; pr_aw = awready; pa_addr = awaddr;
        pv_w = wvalid; pr_w = wready; pw_data = wdata; pw_strb = wstrb;
        pv_ar = arvalid; pr_ar = arready; par_addr = araddr;
        tick();
    endtask

    initial begin
        logic [31:0] d [5];
        int cyc;

        // ---------------- reset ----------------
        tick(); tick();
        chk("rst_ready", iob_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        chk("rst_err", err, 2'b00);
        chk("rst_rvalid", {iob_rvalid, iob_rerr, iob_rdata}, 34'h0);
        chk("rst_prot", {awprot, arprot}, 6'b010_010);
        chk("rst_readies", {bready, rready}, 2'b11);
        rst_n = 1'b1;
        tick();

        // ---------------- 1: single write, AW and W on different cycles ----------------
        iob_valid = 1'b1; iob_addr = 32'h10; iob_wdata = 32'hDEADBEEF; iob_wstrb = 4'hF;
        #1 chk("t1_ready", iob_ready, 1);
        tick();
        iob_valid = 1'b0; iob_wstrb = 4'h0;
        chk("t1_aw", {awvalid, wvalid, awaddr}, {2'b11, 32'h10});
        chk("t1_w", {wdata, wstrb}, {32'hDEADBEEF, 4'hF});
        chk("t1_busy", iob_ready, 0);
        awready = 1'b1; tick(); awready = 1'b0;
        chk("t1_aw_done", {awvalid, wvalid}, 2'b01);
        tick();
        chk("t1_w_hold", {wvalid, wdata}, {1'b1, 32'hDEADBEEF});
        wready = 1'b1; tick(); wready = 1'b0;
        chk("t1_w_done", wvalid, 0);
        chk("t1_not_idle", idle, 0);
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        chk("t1_idle", idle, 1);
        chk("t1_err", err, 2'b00);

        // ---------------- 2: four outstanding reads, fifth blocked ----------------
        arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iob_valid = 1'b1; iob_addr = 32'hA0 + 32'(4 * k);
            #1 chk("t2_ready", iob_ready, 1);
            tick();
            chk("t2_ar", {arvalid, araddr, iob_ready}, {1'b1, 32'hA0 + 32'(4 * k), 1'b0});
            iob_valid = 1'b0;
            tick();
        end
        iob_valid = 1'b1; iob_addr = 32'hB0;
        #1 chk("t2_full", iob_ready, 0);
        tick();
        chk("t2_full_hold", {iob_ready, arvalid}, 2'b00);
        for (int k = 0; k < 5; k++) d[k] = 32'hC0DE_0000 + 32'(k);
        rvalid = 1'b1; rdata = d[0];
        #1 chk("t2_full_at_r", iob_ready, 0);
        tick(); rvalid = 1'b0;
        chk("t2_r0", {iob_rvalid, iob_rdata}, {1'b1, d[0]});
        chk("t2_ready5", iob_ready, 1);
        tick(); iob_valid = 1'b0;
        chk("t2_r0_pulse", iob_rvalid, 0);
        chk("t2_ar5", {arvalid, araddr}, {1'b1, 32'hB0});
        tick();
        for (int k = 1; k < 5; k++) begin
            rvalid = 1'b1; rdata = d[k];
            tick(); rvalid = 1'b0;
            chk("t2_rk", {iob_rvalid, iob_rdata, iob_rerr}, {1'b1, d[k], 1'b0});
            tick();
            chk("t2_rk_pulse", iob_rvalid, 0);
        end
        chk("t2_idle", idle, 1);
        arready = 1'b0;

        // ---------------- 3: write then read, read waits for B ----------------
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        iob_valid = 1'b1; iob_addr = 32'h20; iob_wdata = 32'h12345678; iob_wstrb = 4'hF;
        tick();
        iob_wstrb = 4'h0;
        #1 chk("t3_rd_blocked", iob_ready, 0);
        tick();
        chk("t3_rd_wait_b", {iob_ready, arvalid, awvalid, wvalid}, 4'b0000);
        tick();
        chk("t3_rd_wait_b2", iob_ready, 0);
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        chk("t3_rd_ready", iob_ready, 1);
        tick(); iob_valid = 1'b0;
        chk("t3_ar", {arvalid, araddr}, {1'b1, 32'h20});
        tick();
        chk("t3_ar_done", arvalid, 0);
        rvalid = 1'b1; rdata = 32'h12345678; tick(); rvalid = 1'b0;
        chk("t3_rdata", {iob_rvalid, iob_rdata}, {1'b1, 32'h12345678});
        tick();

        // ---------------- 4: error responses and clear ----------------
        iob_valid = 1'b1; iob_addr = 32'h30; iob_wstrb = 4'h3;
        tick(); iob_valid = 1'b0; iob_wstrb = 4'h0;
        tick();
        bvalid = 1'b1; bresp = 2'b10; tick(); bvalid = 1'b0; bresp = 2'b00;
        chk("t4_bresp_err", err, 2'b01);
        iob_valid = 1'b1; tick(); iob_valid = 1'b0;
        tick();
        rvalid = 1'b1; rresp = 2'b11; rdata = 32'hBAD; tick(); rvalid = 1'b0; rresp = 2'b00;
        chk("t4_rerr", {iob_rvalid, iob_rerr, iob_rdata}, {2'b11, 32'hBAD});
        chk("t4_err", err, 2'b01);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t4_clr", err, 2'b00);

        // ---------------- 5: spurious responses and reset mid-flight ----------------
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        chk("t5_spur_b", {err, idle}, 3'b101);
        iob_wstrb = 4'hF;
        #1 chk("t5_wr_ready", iob_ready, 1);
        iob_wstrb = 4'h0;
        err_clr = 1'b1; bvalid = 1'b1; bresp = 2'b10; tick();
        err_clr = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        chk("t5_new_wins", err, 2'b11);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t5_clr", err, 2'b00);
        arready = 1'b0;
        iob_valid = 1'b1; iob_addr = 32'h40; tick(); iob_valid = 1'b0;
        arready = 1'b1; tick(); arready = 1'b0;
        iob_valid = 1'b1; iob_addr = 32'h44; tick(); iob_valid = 1'b0;
        tick();
        chk("t5_ar_held", {arvalid, idle}, 2'b10);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t5_rst", {arvalid, idle, iob_ready, err}, 5'b01100);
        rvalid = 1'b1; rdata = 32'h55; tick(); rvalid = 1'b0;
        chk("t5_spur_r", {err, idle, iob_rvalid, iob_rdata}, {4'b1011, 32'h55});
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        awready = 1'b0; wready = 1'b0;

        // ---------------- 6: random traffic against the reference model ----------------
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = $urandom;
            s_mem[i]   = ref_mem[i];
        end
        cyc = 0;
        while (ops_done < 1000 && cyc < 30000) begin
            rnd_cycle(1'b1);
            cyc++;
        end
        chk("rnd_ops", ops_done, 1000);
        cyc = 0;
        while (!(exp_rd_q.size() == 0 && s_b_cnt == 0 && s_r_q.size() == 0 && idle && !r_hs_prev)
               && cyc < 2000) begin
            rnd_cycle(1'b0);
            cyc++;
        end
        rnd_cycle(1'b0);
        chk("rnd_drain_idle", idle, 1);
        chk("rnd_aw_count", aw_hs, wr_acc);
        chk("rnd_w_count", w_hs, wr_acc);
        chk("rnd_ar_count", ar_hs, rd_acc);
        chk("rnd_rd_returned", rd_ret, rd_acc);
        chk("rnd_err", err, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
